// File: rtl/regfile.sv
// Two-read, one-write register file with hard-wired zero register and combinational reads.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  // Entry 0 of the read view is a constant; only entries 1..NUM_REGS-1 hold flops.
  logic [DATA_W-1:0] w_regs [NUM_REGS];
  logic              w_wr_any;
  logic              w_byp1;
  logic              w_byp2;

  assign w_wr_any  = we && (waddr != '0);
  assign w_regs[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    logic              w_sel;

    assign w_sel = w_wr_any && (waddr == ADDR_W'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_sel) begin
        r_q <= wdata;
      end
    end

    assign w_regs[gi] = r_q;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding only applies to enabled, non-zero reads of the address being written.
  assign w_byp1 = w_wr_any && re1 && (waddr == raddr1);
  assign w_byp2 = w_wr_any && re2 && (waddr == raddr2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (w_byp1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = w_regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (w_byp2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = w_regs[raddr2];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mdl [NR];

  always #5 clk = ~clk;

  regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  // Reference model: plain array of architectural register values.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) mdl[i] = '0;
    end else if (we && waddr != 0) begin
      mdl[waddr] = wdata;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic en, input logic [AW-1:0] a);
    if (rst || !en || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    check("model_rd1", rdata1, exp_rd(re1, raddr1));
    check("model_rd2", rdata2, exp_rd(re2, raddr2));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  logic [DW-1:0] same_exp;

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #2;
    check("reset_rd1", rdata1, 32'h0);
    check("reset_rd2", rdata2, 32'h0);
    cyc();
    rst = 1'b0;
    idle();

    // Preload, then asynchronous reset pulse between edges.
    for (int n = 1; n < NR; n++) wr(AW'(n), 32'hA5A5_0000 + n);
    re1 = 1'b1; raddr1 = 5'd17; re2 = 1'b1; raddr2 = 5'd31;
    #2;
    check("preload_r17", rdata1, 32'hA5A5_0011);
    check("preload_r31", rdata2, 32'hA5A5_001F);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rd1", rdata1, 32'h0);
    check("async_rst_rd2", rdata2, 32'h0);
    cyc();
    rst = 1'b0;
    for (int a = 1; a < NR; a += 6) begin
      raddr1 = AW'(a); raddr2 = AW'(NR - a);
      #2;
      check("post_rst_rd1", rdata1, 32'h0);
      check("post_rst_rd2", rdata2, 32'h0);
      cyc();
    end
    idle();

    // Basic write then read.
    wr(5'd5, 32'h1234_5678);
    re1 = 1'b1; raddr1 = 5'd5;
    #2;
    check("basic_r5", rdata1, 32'h1234_5678);
    re1 = 1'b0;
    #1;
    check("basic_re_off", rdata1, 32'h0);
    cyc();

    // Zero register ignores writes.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #2;
    check("r0_wcyc_rd1", rdata1, 32'h0);
    check("r0_wcyc_rd2", rdata2, 32'h0);
    cyc();
    we = 1'b0;
    #2;
    check("r0_after_rd1", rdata1, 32'h0);
    check("r0_after_rd2", rdata2, 32'h0);
    cyc();
    idle();

    // Same-cycle write and read of r7.
    wr(5'd7, 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h2;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    same_exp = 32'h2;
`else
    same_exp = 32'h1;
`endif
    #2;
    check("same_cyc_rd1", rdata1, same_exp);
    check("same_cyc_rd2", rdata2, same_exp);
    cyc();
    we = 1'b0;
    #2;
    check("next_cyc_rd1", rdata1, 32'h2);
    check("next_cyc_rd2", rdata2, 32'h2);
    cyc();
    idle();

    // Bypass must respect read enable and address.
    wr(5'd10, 32'h3);
    we = 1'b1; waddr = 5'd9; wdata = 32'hDEAD_BEEF;
    re1 = 1'b0; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd10;
    #2;
    check("gate_rd1", rdata1, 32'h0);
    check("gate_rd2", rdata2, 32'h3);
    cyc();
    idle();

    // Reset coincident with a write edge: clear wins.
    wr(5'd3, 32'h55);
    we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    @(posedge clk);
    rst = 1'b1;
    #1 we = 1'b0;
    cyc();
    rst = 1'b0;
    re1 = 1'b1; raddr1 = 5'd3;
    #2;
    check("rst_wr_r3", rdata1, 32'h0);
    cyc();

    // Randomized traffic, checked by the negedge compare process.
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 79) == 0);
      we     = $urandom_range(0, 3) != 0;
      waddr  = AW'($urandom_range(0, NR - 1));
      wdata  = $urandom;
      re1    = $urandom_range(0, 4) != 0;
      re2    = $urandom_range(0, 4) != 0;
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
